mem_port_arbiter: RTL and testbench

- Sequences and shares the single-port 64-bit data memory between two requesters.
  - Port 0: CPU load/store path.
  - Port 1: DMA / debug loader.
- Round-robin arbitration, one transaction in flight, req/gnt/done handshake.
- Sits between the requesters and data_mem; drives its address, write data and word/byte write strobes; captures read data after a configurable latency.

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter and sequencer for a single-port data memory (one transaction in flight).
// Define ARB_FIXED_PRIO_EN to make port 0 win every tie instead of round-robin.
module mem_port_arbiter #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic [WIDTH-1:0]  wdata1,
    input  logic              we0,
    input  logic              we1,
    input  logic              bwe0,
    input  logic              bwe1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [WIDTH-1:0]  rdata0,
    output logic [WIDTH-1:0]  rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_word_we,
    output logic              mem_byte_we,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              cmd_port_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [WIDTH-1:0]  cmd_wdata_q;
    logic              cmd_we_q;
    logic              cmd_bwe_q;
    logic [WIDTH-1:0]  rdata0_q, rdata1_q;
    logic              cmd_read;
    logic              grant_any;
    logic              grant_port;
    logic              tie_port;
    logic              capture;

    assign cmd_read = !cmd_we_q && !cmd_bwe_q;

`ifdef ARB_FIXED_PRIO_EN
    assign tie_port = 1'b0;
`else
    logic last_grant_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
        end else if (grant_any) begin
            last_grant_q <= grant_port;
        end
    end

    assign tie_port = ~last_grant_q;
`endif

    // Grant is combinational in IDLE and gated by reset so it drops asynchronously.
    always_comb begin
        grant_any  = 1'b0;
        grant_port = 1'b0;
        if (reset && state_q == StIdle) begin
            if (req0 && req1) begin
                grant_any  = 1'b1;
                grant_port = tie_port;
            end else if (req0) begin
                grant_any  = 1'b1;
                grant_port = 1'b0;
            end else if (req1) begin
                grant_any  = 1'b1;
                grant_port = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (grant_any) state_d = StAccess;
            end
            StAccess: begin
                if (!cmd_read || LATENCY == 1) begin
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                    cnt_d   = 3'(LATENCY - 1);
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_port_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_we_q    <= 1'b0;
            cmd_bwe_q   <= 1'b0;
        end else if (grant_any) begin
            cmd_port_q  <= grant_port;
            cmd_addr_q  <= grant_port ? addr1 : addr0;
            cmd_wdata_q <= grant_port ? wdata1 : wdata0;
            cmd_we_q    <= grant_port ? we1 : we0;
            cmd_bwe_q   <= grant_port ? bwe1 : bwe0;
        end
    end

    // Read data is valid in cycle G+LATENCY: the ACCESS cycle itself or the last WAIT cycle.
    assign capture = (state_q == StAccess && cmd_read && LATENCY == 1) ||
                     (state_q == StWait && cnt_q == 3'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (capture) begin
            if (cmd_port_q) begin
                rdata1_q <= mem_rdata;
            end else begin
                rdata0_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        gnt0        = grant_any && !grant_port;
        gnt1        = grant_any && grant_port;
        busy        = state_q != StIdle;
        done0       = state_q == StDone && !cmd_port_q;
        done1       = state_q == StDone && cmd_port_q;
        mem_word_we = state_q == StAccess && cmd_we_q;
        mem_byte_we = state_q == StAccess && !cmd_we_q && cmd_bwe_q;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (state_q == StAccess || state_q == StWait) mem_addr = cmd_addr_q;
        if (state_q == StAccess) mem_wdata = cmd_wdata_q;
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

    a_gnt_excl : assert property (@(posedge clock) disable iff (!reset) !(gnt0 && gnt1));
    a_done_excl : assert property (@(posedge clock) disable iff (!reset) !(done0 && done1));
    a_we_excl : assert property (@(posedge clock) disable iff (!reset)
                                 !(mem_word_we && mem_byte_we));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level reference model.
// Honours ARB_FIXED_PRIO_EN when predicting tie winners.
module tb_mem_port_arbiter;
    localparam int unsigned LAT = 3;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
        logic        bwe;
    } cmd_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [63:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        we0 = 1'b0, we1 = 1'b0, bwe0 = 1'b0, bwe1 = 1'b0;
    logic        gnt0, gnt1, done0, done1, busy, mem_word_we, mem_byte_we;
    logic [63:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    int          passes = 0;
    int          checks = 0;
    int          fails = 0;
    int          last_g = 1;
    logic [63:0] ref_mem [256];
    logic [63:0] exp_rd [2];

    // Physical memory: only the DUT's strobes change it; read data is valid only in cycle G+LAT.
    logic [63:0] phys [256];
    bit          mem_ready = 1'b0;
    int          acc_cyc = 100;

    mem_port_arbiter #(.WIDTH(64), .ADDR_W(64), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1), .bwe0(bwe0), .bwe1(bwe1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_word_we(mem_word_we), .mem_byte_we(mem_byte_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] init_val(input int i);
        return {32'(i) * 32'h9E37_79B9, ~32'(i)};
    endfunction

    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) phys[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (mem_word_we) begin
            phys[mem_addr[7:0]] <= mem_wdata;
        end else if (mem_byte_we) begin
            phys[mem_addr[7:0]][7:0] <= mem_wdata[7:0];
        end
        if (gnt0 || gnt1) acc_cyc <= 0;
        else if (acc_cyc < 100) acc_cyc <= acc_cyc + 1;
    end

    always_comb mem_rdata = (acc_cyc == int'(LAT) - 1) ? phys[mem_addr[7:0]] : 64'hEEEE_EEEE_EEEE_EEEE;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge clock);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clock);
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.addr  = {$urandom, $urandom};
        c.wdata = {$urandom, $urandom};
        c.we    = 1'($urandom_range(0, 1));
        c.bwe   = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin
            c.we  = 1'b0;
            c.bwe = 1'b0;
        end
        return c;
    endfunction

    task automatic drive_port(input int p, input logic r, input cmd_t c);
        if (p == 0) begin
            req0 = r; addr0 = c.addr; wdata0 = c.wdata; we0 = c.we; bwe0 = c.bwe;
        end else begin
            req1 = r; addr1 = c.addr; wdata1 = c.wdata; we1 = c.we; bwe1 = c.bwe;
        end
    endtask

    function automatic int tie_winner();
`ifdef ARB_FIXED_PRIO_EN
        return 0;
`else
        return (last_g == 0) ? 1 : 0;
`endif
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt0"}, gnt0, 0);
        chk({tag, "_gnt1"}, gnt1, 0);
        chk({tag, "_done0"}, done0, 0);
        chk({tag, "_done1"}, done1, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wwe"}, mem_word_we, 0);
        chk({tag, "_bwe"}, mem_byte_we, 0);
        chk({tag, "_maddr"}, mem_addr, 0);
        chk({tag, "_mwdata"}, mem_wdata, 0);
    endtask

    // Entered at the sampling point of grant cycle G; returns at the sampling point of DONE.
    task automatic run_txn(input int p, input cmd_t c, input bit pulse_other);
        bit       rd = !c.we && !c.bwe;
        int       n_wait = rd ? int'(LAT) - 1 : 0;
        int       q = 1 - p;
        logic [7:0] idx = c.addr[7:0];
        chk("gnt_win", (p == 0) ? gnt0 : gnt1, 1);
        chk("gnt_lose", (p == 0) ? gnt1 : gnt0, 0);
        chk("busy_g", busy, 0);
        last_g = p;
        to_drive();
        drive_port(p, 1'b0, rand_cmd());
        if (pulse_other) drive_port(q, 1'b1, rand_cmd());
        to_sample();
        chk("acc_wwe", mem_word_we, c.we);
        chk("acc_bwe", mem_byte_we, !c.we && c.bwe);
        chk("acc_addr", mem_addr, c.addr);
        if (!rd) chk("acc_wdata", mem_wdata, c.wdata);
        chk("acc_busy", busy, 1);
        chk("acc_gnt", {gnt0, gnt1}, 0);
        chk("acc_done", {done0, done1}, 0);
        to_drive();
        if (pulse_other) drive_port(q, 1'b0, rand_cmd());
        for (int i = 0; i < n_wait; i++) begin
            to_sample();
            chk("wait_busy", busy, 1);
            chk("wait_we", {mem_word_we, mem_byte_we}, 0);
            chk("wait_addr", mem_addr, c.addr);
            chk("wait_done", {done0, done1}, 0);
            chk("wait_gnt", {gnt0, gnt1}, 0);
            to_drive();
        end
        to_sample();
        if (c.we) ref_mem[idx] = c.wdata;
        else if (c.bwe) ref_mem[idx][7:0] = c.wdata[7:0];
        if (rd) exp_rd[p] = ref_mem[idx];
        chk("done_win", (p == 0) ? done0 : done1, 1);
        chk("done_lose", (p == 0) ? done1 : done0, 0);
        chk("done_busy", busy, 1);
        chk("done_gnt", {gnt0, gnt1}, 0);
        chk("rdata0", rdata0, exp_rd[0]);
        chk("rdata1", rdata1, exp_rd[1]);
    endtask

    initial begin
        cmd_t c, c0;
        bit   pend [2];
        cmd_t pc [2];
        int   win;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        #12;
        chk_idle("rst");
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        to_sample();
        chk_idle("idle_noreq");

        // Port 0 word write, then port 1 read of the same address.
        to_drive();
        c.addr = 64'h40; c.wdata = 64'hDEAD_BEEF_CAFE_F00D; c.we = 1'b1; c.bwe = 1'b0;
        drive_port(0, 1'b1, c);
        to_sample();
        run_txn(0, c, 1'b0);
        to_drive();
        c.addr = 64'h40; c.wdata = '0; c.we = 1'b0; c.bwe = 1'b0;
        drive_port(1, 1'b1, c);
        to_sample();
        run_txn(1, c, 1'b1);
        chk("rd40_value", rdata1, 64'hDEAD_BEEF_CAFE_F00D);

        // Both requests held continuously.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            to_drive();
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    pend[p] = 1'b1;
                    pc[p] = rand_cmd();
                    drive_port(p, 1'b1, pc[p]);
                end
            end
            win = tie_winner();
            to_sample();
            pend[win] = 1'b0;
            run_txn(win, pc[win], 1'b0);
        end
        to_drive();
        for (int p = 0; p < 2; p++) begin
            if (pend[p]) begin
                to_sample();
                pend[p] = 1'b0;
                run_txn(p, pc[p], 1'b0);
                to_drive();
            end
        end

        // Word and byte write precedence, then port 0 reads the result back.
        c.addr = 64'h80; c.wdata = 64'h1122_3344_5566_77AB; c.we = 1'b1; c.bwe = 1'b1;
        drive_port(0, 1'b1, c);
        to_sample();
        run_txn(0, c, 1'b0);
        to_drive();
        c.wdata = 64'hFFFF_FFFF_FFFF_FF5C; c.we = 1'b0; c.bwe = 1'b1;
        drive_port(0, 1'b1, c);
        to_sample();
        run_txn(0, c, 1'b0);
        to_drive();
        c.wdata = '0; c.we = 1'b0; c.bwe = 1'b0;
        drive_port(0, 1'b1, c);
        to_sample();
        run_txn(0, c, 1'b0);
        chk("byte_rd", rdata0, 64'h1122_3344_5566_775C);

        // Reset asserted during WAIT of a read.
        to_drive();
        c.addr = 64'h40; c.we = 1'b0; c.bwe = 1'b0;
        drive_port(1, 1'b1, c);
        to_sample();
        chk("rw_gnt1", gnt1, 1);
        to_drive();
        drive_port(1, 1'b0, c);
        to_drive();
        c0.addr = 64'h33; c0.wdata = {$urandom, $urandom}; c0.we = 1'b1; c0.bwe = 1'b0;
        drive_port(0, 1'b1, c0);
        #2 reset = 1'b0;
        #1;
        chk_idle("rst_wait");
        chk("rst_wait_rdata0", rdata0, 0);
        chk("rst_wait_rdata1", rdata1, 0);
        to_drive();
        to_drive();
        reset = 1'b1;
        last_g = 1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        to_sample();
        run_txn(0, c0, 1'b0);

        // Randomized traffic.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        repeat (60) begin
            to_drive();
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1'b1;
                    pc[p] = rand_cmd();
                    pc[p].addr[63:8] = (($urandom_range(0, 1) == 1) ? 56'h0 : pc[p].addr[63:8]);
                    drive_port(p, 1'b1, pc[p]);
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1'b1;
                pc[0] = rand_cmd();
                drive_port(0, 1'b1, pc[0]);
            end
            win = (pend[0] && pend[1]) ? tie_winner() : (pend[0] ? 0 : 1);
            to_sample();
            pend[win] = 1'b0;
            run_txn(win, pc[win], !pend[1 - win] && $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
